ram_rw_bridge: RTL

Parametrised memory bridge between up to NCH core memory requesters and a single-port RAMHelper model in the simulation top. Successor to the fixed single-channel, 64-bit, one-cycle-ready RAM hookup. Adds round-robin arbitration, configurable data width and response latency, and byte-to-bit write-mask expansion. Adds base-relative index generation, with optional out-of-range error reporting.

---
 rtl/ram_rw_bridge_pkg.sv | 27 ++
 rtl/ram_rw_bridge_rr_arbiter.sv | 47 ++++
 rtl/ram_rw_bridge.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ram_rw_bridge_pkg.sv
// Shared definitions for the RAM bridge: FSM encoding, default RAM base and pointer sizing.
// Optional out-of-range checking is enabled by defining RAM_BRIDGE_RANGE_CHECK_EN.
`ifndef PC_START
`define PC_START 64'h0000_0000_8000_0000
`endif

package ram_rw_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_t;

`ifdef RAM_BRIDGE_RANGE_CHECK_EN
   localparam bit RANGE_CHECK_EN = 1'b1;
`else
   localparam bit RANGE_CHECK_EN = 1'b0;
`endif

   // A single channel still needs a one-bit pointer so the port stays legal.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ram_rw_bridge_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer, wrapping,
// and moves the pointer past the winner whenever the advance strobe fires.
module rr_arbiter
   import ram_rw_bridge_pkg::*;
#(
   parameter int NCH = 2,
   parameter int PW  = ptr_width(NCH)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [NCH-1:0] req,
   input  logic           advance,
   output logic [NCH-1:0] grant,
   output logic [PW-1:0]  ptr
);

   logic [PW-1:0] gnt_idx;
   logic          found;
   int            j;

   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      found   = 1'b0;
      j       = 0;
      for (int i = 0; i < NCH; i++) begin
         j = int'(ptr) + i;
         if (j >= NCH) begin
            j = j - NCH;
         end
         if (!found && req[j]) begin
            grant[j] = 1'b1;
            gnt_idx  = PW'(j);
            found    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= (gnt_idx == PW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

endmodule

// File: rtl/ram_rw_bridge.sv
// Multi-channel request bridge onto a single-port RAMHelper with configurable latency.
// Define RAM_BRIDGE_RANGE_CHECK_EN to flag and suppress accesses outside the RAM window.
module ram_rw_bridge
   import ram_rw_bridge_pkg::*;
#(
   parameter int                DATA_W = 64,
   parameter int                ADDR_W = 64,
   parameter int                IDX_W  = 16,
   parameter int                NCH    = 2,
   parameter int                LAT    = 1,
   parameter logic [ADDR_W-1:0] BASE   = ADDR_W'(`PC_START)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NCH-1:0]            req_valid,
   output logic [NCH-1:0]            req_ready,
   input  logic [NCH-1:0]            req_wen,
   input  logic [NCH*ADDR_W-1:0]     req_addr,
   input  logic [NCH*DATA_W-1:0]     req_wdata,
   input  logic [NCH*(DATA_W/8)-1:0] req_wmask,
   output logic [NCH-1:0]            resp_valid,
   output logic [DATA_W-1:0]         resp_rdata,
   output logic [NCH-1:0]            resp_err,
   output logic                      ram_en,
   output logic                      ram_wen,
   output logic [IDX_W-1:0]          ram_idx,
   output logic [DATA_W-1:0]         ram_wdata,
   output logic [DATA_W-1:0]         ram_wmask,
   input  logic [DATA_W-1:0]         ram_rdata
);

   localparam int MASK_W    = DATA_W / 8;
   localparam int OFF_BITS  = $clog2(MASK_W);
   localparam int PW        = ptr_width(NCH);
   localparam int CNT_W     = (LAT > 1) ? $clog2(LAT) : 1;
   localparam int WAIT_LAST = (LAT > 1) ? LAT - 2 : 0;

   state_t state, next_state;

   logic [NCH-1:0]    grant;
   logic [PW-1:0]     arb_ptr;
   logic              advance;

   logic              sel_wen;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [MASK_W-1:0] sel_wmask;
   logic [ADDR_W-1:0] offset;
   logic [ADDR_W-1:0] idx_full;
   logic              sel_oor;
   logic [DATA_W-1:0] wmask_bits;

   logic              wen_q;
   logic              oor_q;
   logic [NCH-1:0]    grant_q;
   logic [IDX_W-1:0]  idx_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] wmask_q;
   logic [DATA_W-1:0] rdata_q;
   logic [CNT_W-1:0]  cnt;

   rr_arbiter #(
      .NCH (NCH)
   ) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req_valid),
      .advance (advance),
      .grant   (grant),
      .ptr     (arb_ptr)
   );

   assign advance = |(req_valid & req_ready);

   // The grant is one-hot, so OR-ing the granted slices selects that channel's fields.
   always_comb begin
      sel_wen   = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_wmask = '0;
      for (int c = 0; c < NCH; c++) begin
         if (grant[c]) begin
            sel_wen   = sel_wen | req_wen[c];
            sel_addr  = sel_addr | req_addr[c*ADDR_W +: ADDR_W];
            sel_wdata = sel_wdata | req_wdata[c*DATA_W +: DATA_W];
            sel_wmask = sel_wmask | req_wmask[c*MASK_W +: MASK_W];
         end
      end
   end

   always_comb begin
      offset   = sel_addr - BASE;
      idx_full = offset >> OFF_BITS;
`ifdef RAM_BRIDGE_RANGE_CHECK_EN
      sel_oor  = (sel_addr < BASE) || ((idx_full >> IDX_W) != '0);
`else
      sel_oor  = 1'b0;
`endif
   end

   always_comb begin
      wmask_bits = '0;
      for (int i = 0; i < MASK_W; i++) begin
         wmask_bits[8*i +: 8] = {8{sel_wmask[i]}};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (advance) begin
               next_state = ACCESS;
            end
         end
         ACCESS: begin
            next_state = (LAT == 1) ? RESP : WAIT;
         end
         WAIT: begin
            if (cnt == CNT_W'(WAIT_LAST)) begin
               next_state = RESP;
            end
         end
         RESP: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Out-of-range requests walk the same states but never touch the RAM.
   always_comb begin
      req_ready  = '0;
      resp_valid = '0;
      resp_err   = '0;
      ram_en     = 1'b0;
      ram_wen    = 1'b0;
      if (state == IDLE && rst_n) begin
         req_ready = grant;
      end
      if (state == ACCESS && !oor_q) begin
         ram_en  = 1'b1;
         ram_wen = wen_q;
      end
      if (state == RESP) begin
         resp_valid = grant_q;
`ifdef RAM_BRIDGE_RANGE_CHECK_EN
         resp_err   = oor_q ? grant_q : '0;
`endif
      end
   end

   assign ram_idx    = idx_q;
   assign ram_wdata  = wdata_q;
   assign ram_wmask  = wmask_q;
   assign resp_rdata = rdata_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wen_q   <= 1'b0;
         oor_q   <= 1'b0;
         grant_q <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         rdata_q <= '0;
         cnt     <= '0;
      end else begin
         if (advance) begin
            wen_q   <= sel_wen;
            oor_q   <= sel_oor;
            grant_q <= grant;
            idx_q   <= idx_full[IDX_W-1:0];
            wdata_q <= sel_wdata;
            wmask_q <= sel_wen ? wmask_bits : '0;
         end
         if (state == ACCESS) begin
            rdata_q <= (!wen_q && !oor_q) ? ram_rdata : '0;
         end
         cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
      end
   end

endmodule
